// File: rtl/pc_flow_ctrl_if.sv
// Bundle of the request, operand and control signals exchanged between the
// PC sequencer and its neighbours (hazard unit, execute, decode, PC register).
interface pc_flow_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic             br_taken_i;
  logic             jalr_i;
  logic             halt_i;
  logic             resume_i;
  logic [31:0]      pc_exec_i;
  logic [31:0]      imm_i;
  logic [31:0]      rs1_i;
  logic             pc_en;
  logic [1:0]       pc_type;
  logic [31:0]      pc_exec_o;
  logic [31:0]      imm_o;
  logic [31:0]      rs1_o;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             halted;
  logic [CNT_W-1:0] redirect_cnt;

  // Sequencer side: consumes requests, drives the PC register controls.
  modport master (
    input  stall_i, br_taken_i, jalr_i, halt_i, resume_i,
    input  pc_exec_i, imm_i, rs1_i,
    output pc_en, pc_type, pc_exec_o, imm_o, rs1_o,
    output flush_if_id, flush_id_ex, halted, redirect_cnt
  );

  // Pipeline side: raises requests, observes the PC controls.
  modport slave (
    output stall_i, br_taken_i, jalr_i, halt_i, resume_i,
    output pc_exec_i, imm_i, rs1_i,
    input  pc_en, pc_type, pc_exec_o, imm_o, rs1_o,
    input  flush_if_id, flush_id_ex, halted, redirect_cnt
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Program-counter sequencer: decides each cycle whether the PC advances and
// how (pc+4, pc_exec+imm, rs1+imm), arbitrates execute redirects against
// decode halts and hazard stalls, and produces the pipeline flush strobes.
// Control outputs are combinational so the PC register acts on the decision
// at the same clock edge.
module pc_flow_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int BOOT_DELAY   = 1,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  pc_flow_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_INIT  = 4'(BOOT_DELAY - 1);
  // With a single flush cycle the redirect cycle itself covers it, so FLUSH
  // is never entered and the reload value is irrelevant.
  localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  localparam logic [1:0] TYPE_SEQ  = 2'b00;
  localparam logic [1:0] TYPE_BR   = 2'b01;
  localparam logic [1:0] TYPE_JALR = 2'b11;

  state_t           state;
  logic [3:0]       cnt;
  logic [CNT_W-1:0] redir_cnt;
  logic             redirect;

  // A redirect is only honoured in RUN; BOOT, FLUSH and HALT ignore execute.
  assign redirect         = (state == RUN) && (bus.jalr_i || bus.br_taken_i);
  assign bus.redirect_cnt = redir_cnt;

  // Per-cycle PC decision, fixed priority jalr > branch > halt > stall > seq.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.pc_type     = TYPE_SEQ;
    bus.pc_exec_o   = 32'd0;
    bus.imm_o       = 32'd0;
    bus.rs1_o       = 32'd0;
    bus.flush_if_id = 1'b0;
    bus.flush_id_ex = 1'b0;
    bus.halted      = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.jalr_i) begin
          bus.pc_en       = 1'b1;
          bus.pc_type     = TYPE_JALR;
          bus.rs1_o       = bus.rs1_i;
          bus.imm_o       = bus.imm_i;
          bus.flush_if_id = 1'b1;
          bus.flush_id_ex = 1'b1;
        end else if (bus.br_taken_i) begin
          // Overrides stall: the stalled younger instructions get squashed.
          bus.pc_en       = 1'b1;
          bus.pc_type     = TYPE_BR;
          bus.pc_exec_o   = bus.pc_exec_i;
          bus.imm_o       = bus.imm_i;
          bus.flush_if_id = 1'b1;
          bus.flush_id_ex = 1'b1;
        end else if (bus.halt_i) begin
          bus.flush_if_id = 1'b1;
        end else if (!bus.stall_i) begin
          bus.pc_en = 1'b1;
        end
      end
      FLUSH: begin
        bus.pc_en       = 1'b1;
        bus.flush_if_id = 1'b1;
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: ;
    endcase
  end

  // State, down-counter and redirect counter; reset returns to the boot hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      cnt       <= BOOT_INIT;
      redir_cnt <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          if (cnt == 4'd0) state <= RUN;
          else             cnt   <= cnt - 4'd1;
        end
        RUN: begin
          if (redirect) begin
            redir_cnt <= redir_cnt + 1'b1;
            cnt       <= FLUSH_INIT;
            if (FLUSH_CYCLES > 1) state <= FLUSH;
          end else if (bus.halt_i) begin
            state <= HALT;
          end
        end
        FLUSH: begin
          if (cnt == 4'd0) state <= RUN;
          else             cnt   <= cnt - 4'd1;
        end
        HALT: begin
          if (bus.resume_i) state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl with an abstract reference model
// (remaining-cycle counters and flags) compared on every falling edge,
// plus hand-computed literal checks at key points of each scenario.
module tb_pc_flow_ctrl;

  localparam int FC   = 2;
  localparam int BD   = 1;
  localparam int CW   = 4;
  localparam int OW   = 1 + 2 + 96 + 3 + CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  pc_flow_ctrl_if #(.CNT_W(CW)) bus ();

  pc_flow_ctrl #(
    .FLUSH_CYCLES(FC),
    .BOOT_DELAY  (BD),
    .CNT_W       (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Reference model: cycles of boot hold left, flush cycles left after the
  // redirect cycle, halt flag, and the redirect count as a plain integer.
  int m_boot_left  = BD;
  int m_flush_left = 0;
  bit m_halted     = 1'b0;
  int m_cnt        = 0;

  function automatic logic [OW-1:0] model_out();
    logic        en, fi, fe, h;
    logic [1:0]  ty;
    logic [31:0] pe, im, rs;
    en = 0; fi = 0; fe = 0; h = 0; ty = 2'b00; pe = 0; im = 0; rs = 0;
    if (rst || m_boot_left > 0) begin
      // everything low
    end else if (m_halted) begin
      h = 1;
    end else if (m_flush_left > 0) begin
      en = 1; fi = 1;
    end else if (bus.jalr_i) begin
      en = 1; ty = 2'b11; rs = bus.rs1_i; im = bus.imm_i; fi = 1; fe = 1;
    end else if (bus.br_taken_i) begin
      en = 1; ty = 2'b01; pe = bus.pc_exec_i; im = bus.imm_i; fi = 1; fe = 1;
    end else if (bus.halt_i) begin
      fi = 1;
    end else if (!bus.stall_i) begin
      en = 1;
    end
    return {en, ty, pe, im, rs, fi, fe, h, CW'(m_cnt % (1 << CW))};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.pc_en, bus.pc_type, bus.pc_exec_o, bus.imm_o, bus.rs1_o,
            bus.flush_if_id, bus.flush_id_ex, bus.halted, bus.redirect_cnt};
  endfunction

  // Model state advance, reset asynchronously like the design.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot_left  = BD;
      m_flush_left = 0;
      m_halted     = 1'b0;
      m_cnt        = 0;
    end else if (m_boot_left > 0) begin
      m_boot_left = m_boot_left - 1;
    end else if (m_halted) begin
      if (bus.resume_i) m_halted = 1'b0;
    end else if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
    end else if (bus.jalr_i || bus.br_taken_i) begin
      m_cnt        = (m_cnt + 1) % (1 << CW);
      m_flush_left = FC - 1;
    end else if (bus.halt_i) begin
      m_halted = 1'b1;
    end
  end

  // Every-cycle comparison against the model, plus the idle-output invariant.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [OW-1:0] exp_v, act_v;
      exp_v = model_out();
      act_v = dut_out();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
      if (bus.pc_en === 1'b0) begin
        checks++;
        if ({bus.pc_type, bus.pc_exec_o, bus.imm_o, bus.rs1_o} !== '0) begin
          errors++;
          $display("FAIL idle_invariant t=%0t type=%b pe=%h im=%h rs=%h required all zero",
                   $time, bus.pc_type, bus.pc_exec_o, bus.imm_o, bus.rs1_o);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic j, input logic b, input logic h, input logic s,
                       input logic r, input logic [31:0] pe, input logic [31:0] im,
                       input logic [31:0] rs);
    bus.jalr_i = j; bus.br_taken_i = b; bus.halt_i = h; bus.stall_i = s;
    bus.resume_i = r; bus.pc_exec_i = pe; bus.imm_i = im; bus.rs1_i = rs;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    chk_en = 1'b1;

    // Reset state
    lit("rst_pc_en", 32'(bus.pc_en), 0);
    lit("rst_cnt", 32'(bus.redirect_cnt), 0);
    lit("rst_flush", 32'({bus.flush_if_id, bus.flush_id_ex, bus.halted}), 0);

    // 1: boot hold for one cycle, then sequential fetch
    step(1);
    rst = 1'b0;
    #1;
    lit("boot_pc_en", 32'(bus.pc_en), 0);
    step(1);
    lit("run_pc_en", 32'(bus.pc_en), 1);
    lit("run_type", 32'(bus.pc_type), 0);
    step(1);

    // 2: three stall cycles
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      lit("stall_pc_en", 32'(bus.pc_en), 0);
      lit("stall_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 0);
      step(1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    lit("post_stall_pc_en", 32'(bus.pc_en), 1);
    lit("post_stall_cnt", 32'(bus.redirect_cnt), 0);
    step(1);

    // 3: branch with simultaneous stall
    drive(0, 1, 0, 1, 0, 32'h100, 32'h20, 0);
    lit("br_pc_en", 32'(bus.pc_en), 1);
    lit("br_type", 32'(bus.pc_type), 1);
    lit("br_pc_exec_o", bus.pc_exec_o, 32'h100);
    lit("br_imm_o", bus.imm_o, 32'h20);
    lit("br_flushes", 32'({bus.flush_if_id, bus.flush_id_ex}), 3);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    lit("br_flush_cyc", 32'({bus.pc_en, bus.flush_if_id, bus.flush_id_ex}), 3'b110);
    step(1);
    lit("br_after_flush", 32'({bus.pc_en, bus.flush_if_id}), 2'b10);
    lit("br_cnt", 32'(bus.redirect_cnt), 1);
    step(1);

    // 4: jalr and branch together; branch during FLUSH is ignored
    drive(1, 1, 0, 0, 0, 32'h100, 32'h4, 32'h2000);
    lit("jalr_type", 32'(bus.pc_type), 3);
    lit("jalr_rs1_o", bus.rs1_o, 32'h2000);
    lit("jalr_imm_o", bus.imm_o, 32'h4);
    step(1);
    drive(0, 1, 0, 0, 0, 32'h300, 32'h8, 0);
    lit("flush_br_type", 32'(bus.pc_type), 0);
    lit("flush_br_id_ex", 32'(bus.flush_id_ex), 0);
    lit("jalr_cnt", 32'(bus.redirect_cnt), 2);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    lit("jalr_cnt_hold", 32'(bus.redirect_cnt), 2);
    step(1);

    // 5: halt, ignored requests, resume
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    lit("halt_req", 32'({bus.pc_en, bus.flush_if_id, bus.halted}), 3'b010);
    step(1);
    drive(0, 1, 0, 1, 0, 32'h500, 32'h10, 0);
    for (int i = 0; i < 3; i++) begin
      lit("halted", 32'({bus.pc_en, bus.halted, bus.flush_if_id}), 3'b010);
      step(1);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    lit("resume_cyc", 32'({bus.pc_en, bus.halted}), 2'b01);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    lit("after_resume", 32'({bus.pc_en, bus.halted}), 2'b10);
    lit("halt_cnt", 32'(bus.redirect_cnt), 2);
    step(1);

    // 6: 14 more redirects wrap the 4-bit counter to 0
    for (int i = 0; i < 14; i++) begin
      drive(0, 1, 0, 0, 0, 32'(i * 16), 32'h4, 0);
      step(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step(1);
    end
    lit("wrap_cnt", 32'(bus.redirect_cnt), 0);

    // One more redirect, then reset asynchronously in the FLUSH cycle
    drive(1, 0, 0, 0, 0, 0, 32'h8, 32'h40);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    lit("pre_rst_flush", 32'({bus.pc_en, bus.flush_if_id}), 2'b11);
    lit("pre_rst_cnt", 32'(bus.redirect_cnt), 1);
    #1;
    rst = 1'b1;
    #1;
    lit("async_rst_out", 32'({bus.pc_en, bus.pc_type, bus.flush_if_id, bus.flush_id_ex,
                              bus.halted}), 0);
    lit("async_rst_cnt", 32'(bus.redirect_cnt), 0);
    step(2);
    rst = 1'b0;
    #1;
    lit("reboot_pc_en", 32'(bus.pc_en), 0);
    step(1);
    lit("reboot_run", 32'({bus.pc_en, bus.pc_type}), 3'b100);
    step(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
